fifo_scheduler: RTL and testbench
=================================

Name: fifo_scheduler

Overview:
Controller for the shared byte FIFO (DATA_SIZE wide, FWFT read data, registered full/empty flags, one-cycle write/read strobes).
- Write side: round-robin arbitration of two requesters, A and B, onto the single FIFO write port.
- Read side: FSM that drains the FIFO into a byte transmitter with a busy handshake.
- Sits between the input sources (e.g. keypad/sensor front-ends), the FIFO, and the serial TX block.

Parameters:
DATA_SIZE, 8, byte width; must match the FIFO.
CNT_W, 16, width of the transmitted-byte counter.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
req_a  in  1  requester A wants to write; level, held with data_a stable until gnt_a
data_a  in  DATA_SIZE  requester A byte
gnt_a  out  1  one-cycle pulse: data_a accepted
req_b  in  1  requester B write request; same rules as A
data_b  in  DATA_SIZE  requester B byte
gnt_b  out  1  one-cycle pulse: data_b accepted
fifo_full  in  1  FIFO full flag
fifo_empty  in  1  FIFO empty flag
fifo_rd_data  in  DATA_SIZE  FIFO head byte, valid while fifo_empty=0
fifo_wr  out  1  FIFO write strobe
fifo_wr_data  out  DATA_SIZE  FIFO write byte
fifo_rd  out  1  FIFO read (pop) strobe
drain_en  in  1  allow new pops/transmissions
tx_busy  in  1  transmitter busy
tx_start  out  1  one-cycle start pulse to transmitter
tx_data  out  DATA_SIZE  byte to transmit; held until next start
tx_count  out  CNT_W  bytes handed to transmitter; wraps modulo 2^CNT_W
state  out  2  read FSM state, for debug

Behaviour:
- All outputs are registered.
- Reset (async, any cycle, mid-transfer included): all outputs 0, state=IDLE, round-robin pointer favours A. Any pending grant or transmission is abandoned.

Write arbiter:
- Evaluated in cycle N when at least one req is high, fifo_full=0 and fifo_wr=0.
- Winner selection:
  - Single requester: that requester wins.
  - Both requesting: the requester not granted most recently wins.
- Edge ending cycle N: fifo_wr=1, fifo_wr_data=winner data, gnt_winner=1, all for exactly one cycle (N+1). Pointer updates to the winner.
- No grant while fifo_wr=1 (max one write every 2 cycles). This prevents double-granting a held request and lets the full flag settle.
- Requester must drop req, or present new data, in the cycle after gnt.
- fifo_full=1: no grant, requests wait, no data lost. gnt_a and gnt_b are never both high.
- fifo_wr is never asserted in a cycle following a sample of fifo_full=1.

Read FSM (state encoding: IDLE=0, LOAD=1, WAIT_ACK=2, WAIT_DONE=3):
- IDLE: if drain_en=1, fifo_empty=0 and tx_busy=0, go to LOAD.
- LOAD: one cycle. At exit edge, register tx_data=fifo_rd_data, pulse tx_start=1 and fifo_rd=1 (one cycle each), increment tx_count. Go to WAIT_ACK.
- WAIT_ACK: stay until tx_busy=1, then go to WAIT_DONE.
- WAIT_DONE: stay until tx_busy=0, then go to IDLE.
- fifo_rd is never asserted while fifo_empty=1.
- drain_en falling mid-transfer: current byte completes; no new LOAD.
- Latency, non-empty FIFO to tx_start: 2 cycles (IDLE→LOAD, LOAD→exit).
- Simultaneous fifo_wr and fifo_rd in the same cycle is legal (FIFO non-empty and non-full at that point).
- tx_count wraps from 2^CNT_W-1 to 0.

Test Plan:
- Reset, then req_a=1, data_a=8'h41, FIFO empty → gnt_a and fifo_wr with fifo_wr_data=8'h41 pulse in cycle 2; gnt_b stays 0.
- req_a and req_b held high continuously (A=8'h11, B=8'h22) → grants alternate A,B,A,B, one every 2 cycles; FIFO receives 11,22,11,22.
- fifo_full=1 with req_b=1 → no gnt_b or fifo_wr. Deassert full → gnt_b 1 cycle later; data_b written once.
- FIFO holds 8'h5A, drain_en=1, tx_busy low; model raises busy 1 cycle after tx_start for 10 cycles → tx_start and fifo_rd pulse together once, tx_data=8'h5A, tx_count=1, FSM returns to IDLE after busy falls.
- drain_en=0 with FIFO non-empty → no tx_start. Drop drain_en during WAIT_DONE → current byte finishes; no second start.
- Assert reset while in WAIT_DONE with fifo_wr pulsing → all outputs 0, state=0, tx_count=0. Next contention between A and B grants A first.

Source files
------------

// File: rtl/fifo_scheduler.sv
// Shared byte FIFO controller: round-robin write arbitration of requesters A/B and
// a read FSM that drains the FIFO into a byte transmitter using a busy handshake.
module fifo_scheduler #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_a_i,
  input  logic [DATA_SIZE-1:0] data_a_i,
  output logic                 gnt_a_o,
  input  logic                 req_b_i,
  input  logic [DATA_SIZE-1:0] data_b_i,
  output logic                 gnt_b_o,
  input  logic                 fifo_full_i,
  input  logic                 fifo_empty_i,
  input  logic [DATA_SIZE-1:0] fifo_rd_data_i,
  output logic                 fifo_wr_o,
  output logic [DATA_SIZE-1:0] fifo_wr_data_o,
  output logic                 fifo_rd_o,
  input  logic                 drain_en_i,
  input  logic                 tx_busy_i,
  output logic                 tx_start_o,
  output logic [DATA_SIZE-1:0] tx_data_o,
  output logic [CNT_W-1:0]     tx_count_o,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StLoad     = 2'd1,
    StWaitAck  = 2'd2,
    StWaitDone = 2'd3
  } rd_state_e;

  // ---------------------------------------------------------------------------
  // Write arbiter
  // ---------------------------------------------------------------------------
  logic                 gnt_a_q, gnt_a_d;
  logic                 gnt_b_q, gnt_b_d;
  logic                 fifo_wr_q, fifo_wr_d;
  logic [DATA_SIZE-1:0] wr_data_q, wr_data_d;
  logic                 prio_b_q, prio_b_d;  // 1: B was not granted most recently
  logic                 can_grant;
  logic                 win_a, win_b;

  // Blocking on our own write strobe keeps a held request from being granted twice
  // and gives the FIFO a cycle to update its full flag.
  assign can_grant = !fifo_full_i && !fifo_wr_q;
  assign win_a     = can_grant && req_a_i && (!req_b_i || !prio_b_q);
  assign win_b     = can_grant && req_b_i && (!req_a_i || prio_b_q);

  always_comb begin
    gnt_a_d   = 1'b0;
    gnt_b_d   = 1'b0;
    fifo_wr_d = 1'b0;
    wr_data_d = wr_data_q;
    prio_b_d  = prio_b_q;
    if (win_a) begin
      gnt_a_d   = 1'b1;
      fifo_wr_d = 1'b1;
      wr_data_d = data_a_i;
      prio_b_d  = 1'b1;
    end else if (win_b) begin
      gnt_b_d   = 1'b1;
      fifo_wr_d = 1'b1;
      wr_data_d = data_b_i;
      prio_b_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_a_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
      fifo_wr_q <= 1'b0;
      wr_data_q <= '0;
      prio_b_q  <= 1'b0;
    end else begin
      gnt_a_q   <= gnt_a_d;
      gnt_b_q   <= gnt_b_d;
      fifo_wr_q <= fifo_wr_d;
      wr_data_q <= wr_data_d;
      prio_b_q  <= prio_b_d;
    end
  end

  assign gnt_a_o        = gnt_a_q;
  assign gnt_b_o        = gnt_b_q;
  assign fifo_wr_o      = fifo_wr_q;
  assign fifo_wr_data_o = wr_data_q;

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  rd_state_e            state_q, state_d;
  logic                 fifo_rd_q, fifo_rd_d;
  logic                 tx_start_q, tx_start_d;
  logic [DATA_SIZE-1:0] tx_data_q, tx_data_d;
  logic [CNT_W-1:0]     tx_count_q, tx_count_d;
  logic                 load_fire;

  // A pop is only issued from LOAD with the FIFO still showing data.
  assign load_fire = (state_q == StLoad) && !fifo_empty_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (drain_en_i && !fifo_empty_i && !tx_busy_i) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        state_d = load_fire ? StWaitAck : StIdle;
      end
      StWaitAck: begin
        if (tx_busy_i) begin
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (!tx_busy_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    fifo_rd_d  = 1'b0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    tx_count_d = tx_count_q;
    if (load_fire) begin
      fifo_rd_d  = 1'b1;
      tx_start_d = 1'b1;
      tx_data_d  = fifo_rd_data_i;
      tx_count_d = tx_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_rd_q  <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      tx_count_q <= '0;
    end else begin
      fifo_rd_q  <= fifo_rd_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      tx_count_q <= tx_count_d;
    end
  end

  assign fifo_rd_o  = fifo_rd_q;
  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;
  assign tx_count_o = tx_count_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_fifo_scheduler.sv
// Directed bench for fifo_scheduler: FIFO flags and transmitter busy are driven by hand.
module tb_fifo_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_a, req_b, gnt_a, gnt_b;
  logic [7:0] data_a, data_b;
  logic       fifo_full, fifo_empty, fifo_wr, fifo_rd;
  logic [7:0] fifo_rd_data, fifo_wr_data;
  logic       drain_en, tx_busy, tx_start;
  logic [7:0] tx_data;
  logic [15:0] tx_count;
  logic [1:0] state;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fifo_scheduler #(.DATA_SIZE(8), .CNT_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_a_i        (req_a),
    .data_a_i       (data_a),
    .gnt_a_o        (gnt_a),
    .req_b_i        (req_b),
    .data_b_i       (data_b),
    .gnt_b_o        (gnt_b),
    .fifo_full_i    (fifo_full),
    .fifo_empty_i   (fifo_empty),
    .fifo_rd_data_i (fifo_rd_data),
    .fifo_wr_o      (fifo_wr),
    .fifo_wr_data_o (fifo_wr_data),
    .fifo_rd_o      (fifo_rd),
    .drain_en_i     (drain_en),
    .tx_busy_i      (tx_busy),
    .tx_start_o     (tx_start),
    .tx_data_o      (tx_data),
    .tx_count_o     (tx_count),
    .state_o        (state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_a = 0; req_b = 0; data_a = 0; data_b = 0;
    fifo_full = 0; fifo_empty = 1; fifo_rd_data = 0; drain_en = 0; tx_busy = 0;
    tick();
    tick();
    if ({gnt_a, gnt_b, fifo_wr, fifo_rd, tx_start} !== 5'b0) begin
      $display("FAIL reset_strobes: got %b want 00000", {gnt_a, gnt_b, fifo_wr, fifo_rd, tx_start});
      n_fail++;
    end
    n_cmp++;
    if (fifo_wr_data !== 8'h00) begin $display("FAIL reset_wr_data: got %0h want 0", fifo_wr_data); n_fail++; end
    n_cmp++;
    if (tx_data !== 8'h00) begin $display("FAIL reset_tx_data: got %0h want 0", tx_data); n_fail++; end
    n_cmp++;
    if (tx_count !== 16'h0) begin $display("FAIL reset_tx_count: got %0h want 0", tx_count); n_fail++; end
    n_cmp++;
    if (state !== 2'd0) begin $display("FAIL reset_state: got %0d want 0", state); n_fail++; end
    n_cmp++;
    reset = 1'b0;
  endtask

  task automatic test_single_a();
    req_a = 1; data_a = 8'h41;
    tick();
    if (gnt_a !== 1'b1) begin $display("FAIL single_gnt_a: got %b want 1", gnt_a); n_fail++; end
    n_cmp++;
    if (fifo_wr !== 1'b1) begin $display("FAIL single_wr: got %b want 1", fifo_wr); n_fail++; end
    n_cmp++;
    if (fifo_wr_data !== 8'h41) begin $display("FAIL single_data: got %0h want 41", fifo_wr_data); n_fail++; end
    n_cmp++;
    if (gnt_b !== 1'b0) begin $display("FAIL single_gnt_b: got %b want 0", gnt_b); n_fail++; end
    n_cmp++;
    req_a = 0;
    tick();
    if ({gnt_a, fifo_wr} !== 2'b00) begin $display("FAIL single_pulse_end: got %b want 00", {gnt_a, fifo_wr}); n_fail++; end
    n_cmp++;
    tick();
  endtask

  task automatic test_alternate();
    logic ea, eb;
    logic [7:0] ed;
    do_reset();
    req_a = 1; data_a = 8'h11; req_b = 1; data_b = 8'h22;
    for (int i = 0; i < 8; i++) begin
      tick();
      ea = (i % 4 == 0);
      eb = (i % 4 == 2);
      ed = ea ? 8'h11 : 8'h22;
      if ({gnt_a, gnt_b} !== {ea, eb}) begin
        $display("FAIL alt_gnt[%0d]: got %b want %b", i, {gnt_a, gnt_b}, {ea, eb}); n_fail++;
      end
      n_cmp++;
      if (fifo_wr !== (ea | eb)) begin
        $display("FAIL alt_wr[%0d]: got %b want %b", i, fifo_wr, ea | eb); n_fail++;
      end
      n_cmp++;
      if ((ea | eb) && fifo_wr_data !== ed) begin
        $display("FAIL alt_data[%0d]: got %0h want %0h", i, fifo_wr_data, ed); n_fail++;
      end
      n_cmp++;
    end
    req_a = 0; req_b = 0;
    tick();
  endtask

  task automatic test_full();
    fifo_full = 1; req_b = 1; data_b = 8'h33;
    for (int i = 0; i < 3; i++) begin
      tick();
      if ({gnt_b, fifo_wr} !== 2'b00) begin
        $display("FAIL full_hold[%0d]: got %b want 00", i, {gnt_b, fifo_wr}); n_fail++;
      end
      n_cmp++;
    end
    fifo_full = 0;
    tick();
    if ({gnt_b, fifo_wr} !== 2'b11) begin $display("FAIL full_release: got %b want 11", {gnt_b, fifo_wr}); n_fail++; end
    n_cmp++;
    if (fifo_wr_data !== 8'h33) begin $display("FAIL full_data: got %0h want 33", fifo_wr_data); n_fail++; end
    n_cmp++;
    req_b = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if ({gnt_b, fifo_wr} !== 2'b00) begin
        $display("FAIL full_once[%0d]: got %b want 00", i, {gnt_b, fifo_wr}); n_fail++;
      end
      n_cmp++;
    end
  endtask

  task automatic test_drain();
    fifo_empty = 0; fifo_rd_data = 8'h5A; drain_en = 1; tx_busy = 0;
    tick();
    if (state !== 2'd1 || tx_start !== 1'b0) begin
      $display("FAIL drain_load: got state %0d start %b want 1 0", state, tx_start); n_fail++;
    end
    n_cmp++;
    tick();
    if ({tx_start, fifo_rd} !== 2'b11) begin $display("FAIL drain_start: got %b want 11", {tx_start, fifo_rd}); n_fail++; end
    n_cmp++;
    if (tx_data !== 8'h5A) begin $display("FAIL drain_tx_data: got %0h want 5a", tx_data); n_fail++; end
    n_cmp++;
    if (tx_count !== 16'd1) begin $display("FAIL drain_count: got %0d want 1", tx_count); n_fail++; end
    n_cmp++;
    if (state !== 2'd2) begin $display("FAIL drain_wait_ack: got %0d want 2", state); n_fail++; end
    n_cmp++;
    fifo_empty = 1; tx_busy = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (state !== 2'd3 || {tx_start, fifo_rd} !== 2'b00) begin
        $display("FAIL drain_busy[%0d]: got state %0d strobes %b want 3 00", i, state, {tx_start, fifo_rd});
        n_fail++;
      end
      n_cmp++;
    end
    tx_busy = 0;
    tick();
    if (state !== 2'd0) begin $display("FAIL drain_idle: got %0d want 0", state); n_fail++; end
    n_cmp++;
    tick();
    if (tx_count !== 16'd1 || tx_data !== 8'h5A) begin
      $display("FAIL drain_hold: got count %0d data %0h want 1 5a", tx_count, tx_data); n_fail++;
    end
    n_cmp++;
  endtask

  task automatic test_drain_gate();
    drain_en = 0; fifo_empty = 0; fifo_rd_data = 8'h77;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (state !== 2'd0 || tx_start !== 1'b0) begin
        $display("FAIL gate_off[%0d]: got state %0d start %b want 0 0", i, state, tx_start); n_fail++;
      end
      n_cmp++;
    end
    drain_en = 1;
    tick();
    tick();
    if (tx_start !== 1'b1 || tx_data !== 8'h77 || tx_count !== 16'd2) begin
      $display("FAIL gate_start: got start %b data %0h count %0d want 1 77 2", tx_start, tx_data, tx_count);
      n_fail++;
    end
    n_cmp++;
    tx_busy = 1;
    tick();
    drain_en = 0;
    if (state !== 2'd3) begin $display("FAIL gate_wait_done: got %0d want 3", state); n_fail++; end
    n_cmp++;
    tick();
    tick();
    tx_busy = 0;
    tick();
    if (state !== 2'd0) begin $display("FAIL gate_finish: got %0d want 0", state); n_fail++; end
    n_cmp++;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (state !== 2'd0 || tx_start !== 1'b0) begin
        $display("FAIL gate_no_restart[%0d]: got state %0d start %b want 0 0", i, state, tx_start); n_fail++;
      end
      n_cmp++;
    end
    if (tx_count !== 16'd2) begin $display("FAIL gate_count: got %0d want 2", tx_count); n_fail++; end
    n_cmp++;
  endtask

  task automatic test_reset_mid();
    drain_en = 1; fifo_empty = 0; fifo_rd_data = 8'h99; tx_busy = 0;
    tick();
    tick();
    if (tx_count !== 16'd3) begin $display("FAIL mid_count: got %0d want 3", tx_count); n_fail++; end
    n_cmp++;
    tx_busy = 1; fifo_empty = 1;
    tick();
    req_a = 1; data_a = 8'hAA;
    tick();
    if (state !== 2'd3 || fifo_wr !== 1'b1 || gnt_a !== 1'b1) begin
      $display("FAIL mid_setup: got state %0d wr %b gnt_a %b want 3 1 1", state, fifo_wr, gnt_a); n_fail++;
    end
    n_cmp++;
    #2 reset = 1'b1;
    #1;
    if ({gnt_a, gnt_b, fifo_wr, fifo_rd, tx_start} !== 5'b0 || state !== 2'd0 || tx_count !== 16'd0
        || tx_data !== 8'h00 || fifo_wr_data !== 8'h00) begin
      $display("FAIL mid_async_reset: got strobes %b state %0d count %0d data %0h wdata %0h want all 0",
               {gnt_a, gnt_b, fifo_wr, fifo_rd, tx_start}, state, tx_count, tx_data, fifo_wr_data);
      n_fail++;
    end
    n_cmp++;
    req_a = 1; data_a = 8'h11; req_b = 1; data_b = 8'h22;
    tx_busy = 0; drain_en = 0;
    tick();
    reset = 1'b0;
    tick();
    if ({gnt_a, gnt_b} !== 2'b10 || fifo_wr_data !== 8'h11) begin
      $display("FAIL mid_first_a: got gnt %b data %0h want 10 11", {gnt_a, gnt_b}, fifo_wr_data); n_fail++;
    end
    n_cmp++;
    tick();
    tick();
    if ({gnt_a, gnt_b} !== 2'b01 || fifo_wr_data !== 8'h22) begin
      $display("FAIL mid_then_b: got gnt %b data %0h want 01 22", {gnt_a, gnt_b}, fifo_wr_data); n_fail++;
    end
    n_cmp++;
    req_a = 0; req_b = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_alternate();
    test_full();
    test_drain();
    test_drain_gate();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
